// File: rtl/ahb_slave_if_param.sv
// AHB front end of the AHB2APB bridge: decodes NUM_SLV equal APB regions, captures the
// transfer, stalls the bus with wait states while the APB side works, and returns ERROR on bad accesses.
module ahb_slave_if_param #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_SLV   = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h4000_0000),
  parameter int                RGN_LOG2  = 12
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [ADDR_W-1:0]  HADDR,
  input  logic [DATA_W-1:0]  HWDATA,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic               HREADYin,
  input  logic [DATA_W-1:0]  PRDATA,
  input  logic               xfer_done,
  output logic [DATA_W-1:0]  HRDATA,
  output logic               HREADYout,
  output logic [1:0]         HRESP,
  output logic               valid,
  output logic [ADDR_W-1:0]  HADDR_Q,
  output logic [DATA_W-1:0]  HWDATA_Q,
  output logic               HWRITE_Q,
  output logic [2:0]         HSIZE_Q,
  output logic [NUM_SLV-1:0] TEMP_SEL
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WDATA = 3'd1,
    S_PEND  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR1  = 3'd4,
    S_ERR2  = 3'd5
  } state_e;

  localparam int              SIZE_MAX = $clog2(DATA_W / 8);
  // One bit wider than the address so a map reaching the top of the address space still compares correctly.
  localparam logic [ADDR_W:0] RGN_SPAN = (ADDR_W + 1)'(NUM_SLV) << RGN_LOG2;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   haddr_q, haddr_d;
  logic [DATA_W-1:0]   hwdata_q, hwdata_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;
  logic                hwrite_q, hwrite_d;
  logic [2:0]          hsize_q, hsize_d;
  logic [NUM_SLV-1:0]  temp_sel_q, temp_sel_d;
  logic                hready_q, hready_d;
  logic [1:0]          hresp_q, hresp_d;
  logic                valid_q, valid_d;

  logic                accept_s;
  logic [ADDR_W-1:0]   offset_s;
  logic [ADDR_W-1:0]   rgn_idx_s;
  logic                hit_s;
  logic [6:0]          align_mask_s;
  logic                dec_err_s;
  logic [NUM_SLV-1:0]  sel_s;

  // Address decode and alignment check of the address-phase inputs
  always_comb begin
    offset_s     = HADDR - BASE_ADDR;
    rgn_idx_s    = offset_s >> RGN_LOG2;
    hit_s        = ({1'b0, offset_s} < RGN_SPAN);
    align_mask_s = ~(7'h7F << HSIZE);
    dec_err_s    = !hit_s || (HSIZE > 3'(SIZE_MAX)) || (|(HADDR[6:0] & align_mask_s));
    sel_s        = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_s[i] = hit_s && (rgn_idx_s == ADDR_W'(i));
    end
    accept_s = ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2)) &&
               HREADYin && HTRANS[1];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept_s) begin
          if (dec_err_s) begin
            state_d = S_ERR1;
          end else if (HWRITE) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_PEND;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WDATA: state_d = S_PEND;
      S_PEND: begin
        if (xfer_done) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PEND;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // Captured transfer attributes, write data and read data
  always_comb begin
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    temp_sel_d = temp_sel_q;
    hwdata_d   = hwdata_q;
    hrdata_d   = hrdata_q;
    if (accept_s) begin
      haddr_d    = HADDR;
      hwrite_d   = HWRITE;
      hsize_d    = HSIZE;
      temp_sel_d = dec_err_s ? '0 : sel_s;
    end else begin
      haddr_d    = haddr_q;
      temp_sel_d = temp_sel_q;
    end
    if (state_q == S_WDATA) begin
      hwdata_d = HWDATA;
    end else begin
      hwdata_d = hwdata_q;
    end
    if ((state_q == S_PEND) && xfer_done && !hwrite_q) begin
      hrdata_d = PRDATA;
    end else begin
      hrdata_d = hrdata_q;
    end
  end

  // Moore outputs decoded from the next state so they leave a flop
  always_comb begin
    hready_d = 1'b1;
    hresp_d  = 2'b00;
    valid_d  = 1'b0;
    case (state_d)
      S_IDLE:  begin hready_d = 1'b1; hresp_d = 2'b00; end
      S_WDATA: begin hready_d = 1'b0; hresp_d = 2'b00; end
      S_PEND:  begin hready_d = 1'b0; hresp_d = 2'b00; valid_d = 1'b1; end
      S_DONE:  begin hready_d = 1'b1; hresp_d = 2'b00; end
      S_ERR1:  begin hready_d = 1'b0; hresp_d = 2'b01; end
      S_ERR2:  begin hready_d = 1'b1; hresp_d = 2'b01; end
      default: begin hready_d = 1'b1; hresp_d = 2'b00; end
    endcase
  end

  // State and datapath registers; reset drops any transfer in flight
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      haddr_q    <= '0;
      hwdata_q   <= '0;
      hrdata_q   <= '0;
      hwrite_q   <= 1'b0;
      hsize_q    <= 3'd0;
      temp_sel_q <= '0;
      hready_q   <= 1'b1;
      hresp_q    <= 2'b00;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      hwdata_q   <= hwdata_d;
      hrdata_q   <= hrdata_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      temp_sel_q <= temp_sel_d;
      hready_q   <= hready_d;
      hresp_q    <= hresp_d;
      valid_q    <= valid_d;
    end
  end

  assign HRDATA    = hrdata_q;
  assign HREADYout = hready_q;
  assign HRESP     = hresp_q;
  assign valid     = valid_q;
  assign HADDR_Q   = haddr_q;
  assign HWDATA_Q  = hwdata_q;
  assign HWRITE_Q  = hwrite_q;
  assign HSIZE_Q   = hsize_q;
  assign TEMP_SEL  = temp_sel_q;

endmodule
